// File: rtl/gate_vector_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_if : stimulus/response bundle between the checker and a basic-gate unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface gate_if;
  logic a_out;
  logic b_out;
  logic and_g;
  logic or_g;
  logic not_a_g;
  logic xor_g;
  logic xnor_g;
  logic nand_g;

  // master = checker (drives a/b, samples the six gate results)
  modport master (
    output a_out, b_out,
    input  and_g, or_g, not_a_g, xor_g, xnor_g, nand_g
  );

  // slave = gate unit under check
  modport slave (
    input  a_out, b_out,
    output and_g, or_g, not_a_g, xor_g, xnor_g, nand_g
  );
endinterface
`default_nettype wire

// File: rtl/gate_vector_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_vector_checker : walks the four (a,b) vectors through a basic-gate unit
// and reports pass/fail, error count, failing-vector mask and first mismatch.
// Rev 1.0
// ---------------------------------------------------------------------------
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  gate_if.master     gate,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask,
  output logic [5:0] first_fail
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_out_q, a_out_d;
  logic       b_out_q, b_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [5:0] first_fail_q, first_fail_d;

  logic       va;
  logic       vb;
  logic [5:0] resp;
  logic [5:0] expv;
  logic [5:0] mism;

  assign va = idx_q[1];
  assign vb = idx_q[0];

  // Case inequality makes an X/Z response count as a mismatch in simulation.
  always_comb begin
    resp = {gate.nand_g, gate.xnor_g, gate.xor_g, gate.not_a_g, gate.or_g, gate.and_g};
    expv = {~(va & vb), ~(va ^ vb), va ^ vb, ~va, va | vb, va & vb};
    for (int k = 0; k < 6; k++) begin
      mism[k] = (resp[k] !== expv[k]);
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_mask_d  = fail_mask_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SETTLE;
          idx_d        = 2'd0;
          cnt_d        = SETTLE_LOAD;
          pass_d       = 1'b0;
          err_cnt_d    = 3'd0;
          fail_mask_d  = 4'd0;
          first_fail_d = 6'd0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (|mism) begin
          err_cnt_d          = err_cnt_q + 3'd1;
          fail_mask_d[idx_q] = 1'b1;
          if (err_cnt_q == 3'd0) begin
            first_fail_d = mism;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          pass_d  = (err_cnt_d == 3'd0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they are glitch-free.
    busy_d  = (state_d == SETTLE) || (state_d == CHECK);
    done_d  = (state_d == DONE);
    a_out_d = busy_d & idx_d[1];
    b_out_d = busy_d & idx_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 8'd0;
      a_out_q      <= 1'b0;
      b_out_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= 3'd0;
      fail_mask_q  <= 4'd0;
      first_fail_q <= 6'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_mask_q  <= fail_mask_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign gate.a_out = a_out_q;
  assign gate.b_out = b_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_mask  = fail_mask_q;
  assign first_fail = first_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gate_vector_checker : gate-unit model with injectable faults, timeline
// reference model of the checker, directed scenarios plus random traffic.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_gate_vector_checker;
  localparam int S = 2;
  localparam int L = 4 * (S + 1);   // busy cycles of one sequence

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask;
  logic [5:0] first_fail;

  int checks = 0;
  int errs   = 0;

  gate_if gif ();

  gate_vector_checker #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .gate       (gif.master),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_mask  (fail_mask),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  // fault modes: 0 none, 1 and stuck 0, 2 xor inverted, 3 not_a stuck 1, 4 random flips
  int               fault_mode = 0;
  logic [3:0][5:0]  flip_tab   = '0;

  // bit order {nand,xnor,xor,not_a,or,and}
  function automatic logic [5:0] ideal(input logic a, input logic b);
    return {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction

  function automatic logic [5:0] unit_resp(input int mode, input logic a, input logic b,
                                           input logic [5:0] flip);
    logic [5:0] r;
    r = ideal(a, b);
    case (mode)
      1: r[0] = 1'b0;
      2: r[3] = ~r[3];
      3: r[2] = 1'b1;
      4: r = r ^ flip;
      default: ;
    endcase
    return r;
  endfunction

  logic [5:0] unit_r;
  always_comb begin
    unit_r = unit_resp(fault_mode, gif.a_out, gif.b_out, flip_tab[{gif.a_out, gif.b_out}]);
    gif.and_g   = unit_r[0];
    gif.or_g    = unit_r[1];
    gif.not_a_g = unit_r[2];
    gif.xor_g   = unit_r[3];
    gif.xnor_g  = unit_r[4];
    gif.nand_g  = unit_r[5];
  end

  // Expected final report for one full sequence: {pass, err, mask, first}
  function automatic logic [13:0] expected_report(input int mode, input logic [3:0][5:0] flips);
    logic [2:0] e;
    logic [3:0] m;
    logic [5:0] f;
    logic [5:0] d;
    e = 0; m = 0; f = 0;
    for (int i = 0; i < 4; i++) begin
      d = unit_resp(mode, i[1], i[0], flips[i]) ^ ideal(i[1], i[0]);
      if (d != 0) begin
        if (e == 0) f = d;
        e = e + 1;
        m[i] = 1'b1;
      end
    end
    return {(e == 0), e, m, f};
  endfunction

  // Reference model: m_k counts cycles since the edge that accepted start (1 = first cycle).
  logic        m_run = 1'b0;
  int          m_k   = 0;
  logic [13:0] m_res = '0;
  logic [13:0] p_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_k   <= 0;
      m_res <= '0;
      p_res <= '0;
    end else if (m_run) begin
      if (m_k == L + 1) begin
        m_run <= 1'b0;
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == L + 1) m_res <= p_res;
      end
    end else if (start) begin
      m_run <= 1'b1;
      m_k   <= 1;
      m_res <= '0;
      p_res <= expected_report(fault_mode, flip_tab);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic exp_busy, exp_done, exp_a, exp_b;
    int   idx;
    exp_busy = m_run && (m_k <= L);
    exp_done = m_run && (m_k == L + 1);
    idx      = (m_k - 1) / (S + 1);
    exp_a    = exp_busy && (((idx >> 1) & 1) == 1);
    exp_b    = exp_busy && ((idx & 1) == 1);
    check("busy",  8'(busy),      8'(exp_busy));
    check("done",  8'(done),      8'(exp_done));
    check("a_out", 8'(gif.a_out), 8'(exp_a));
    check("b_out", 8'(gif.b_out), 8'(exp_b));
    if (exp_busy) begin
      check("pass_cleared", 8'(pass), 8'd0);
    end else begin
      check("pass",       8'(pass),       8'(m_res[13]));
      check("err_cnt",    8'(err_cnt),    8'(m_res[12:10]));
      check("fail_mask",  8'(fail_mask),  8'(m_res[9:6]));
      check("first_fail", 8'(first_fail), 8'(m_res[5:0]));
    end
  end

  // One run: returns the cycle number (1-based after the sampling edge) of done.
  task automatic run_seq(input int mode, input bit repulse, output int lat);
    int dones;
    @(posedge clk);
    #1 fault_mode = mode;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (repulse) start = (n == 1) || (n == 3) || (n == 13);
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      errs++;
      checks++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("extra_done", 8'(dones), 8'd0);
  endtask

  task automatic check_report(input string tag, input logic p, input logic [2:0] e,
                              input logic [3:0] m, input logic [5:0] f);
    check({tag, "_pass"},  8'(pass),       8'(p));
    check({tag, "_err"},   8'(err_cnt),    8'(e));
    check({tag, "_mask"},  8'(fail_mask),  8'(m));
    check({tag, "_first"}, 8'(first_fail), 8'(f));
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 8'(busy), 8'd0);
    check("reset_err",  8'(err_cnt), 8'd0);
    rst_n = 1'b1;

    run_seq(0, 1'b0, lat);
    check("lat_good", 8'(lat), 8'd13);
    check_report("good", 1'b1, 3'd0, 4'b0000, 6'b000000);

    run_seq(1, 1'b0, lat);
    check_report("and_sa0", 1'b0, 3'd1, 4'b1000, 6'b000001);

    run_seq(2, 1'b0, lat);
    check_report("xor_inv", 1'b0, 3'd4, 4'b1111, 6'b001000);  // xor sits at bit 3

    run_seq(3, 1'b0, lat);
    check_report("nota_sa1", 1'b0, 3'd2, 4'b1100, 6'b000100);
    run_seq(0, 1'b0, lat);
    check_report("clear_on_start", 1'b1, 3'd0, 4'b0000, 6'b000000);

    run_seq(0, 1'b1, lat);
    check("lat_repulse", 8'(lat), 8'd13);

    // Reset while vector 2 is on the bus (cycles 7..9 after start)
    @(posedge clk);
    #1 fault_mode = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_vec_a", 8'(gif.a_out), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_a",     8'(gif.a_out), 8'd0);
    check("rst_b",     8'(gif.b_out), 8'd0);
    check("rst_busy",  8'(busy),      8'd0);
    check("rst_done",  8'(done),      8'd0);
    check("rst_pass",  8'(pass),      8'd0);
    check("rst_err",   8'(err_cnt),   8'd0);
    check("rst_mask",  8'(fail_mask), 8'd0);
    check("rst_first", 8'(first_fail), 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_seq(0, 1'b0, lat);
    check("lat_after_rst", 8'(lat), 8'd13);
    check_report("after_rst", 1'b1, 3'd0, 4'b0000, 6'b000000);

    // Random traffic: faults change only while idle, start toggles freely
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!rst_n) rst_n = 1'b1;
      if (!m_run && $urandom_range(0, 3) == 0) begin
        fault_mode = int'($urandom_range(0, 4));
        flip_tab   = 24'($urandom);
      end
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
    end
    @(posedge clk);
    #1 start = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
`default_nettype wire
